// File: rtl/reg_capture_fifo_if.sv
// Host register bus (reg_main) between the software-facing master and the capture FIFO.
interface reg_capture_fifo_if;
    logic [5:0]  reg_address;
    logic [15:0] reg_bytecnt;
    logic        reg_addrvalid;
    logic        reg_read;
    logic        reg_write;
    logic [7:0]  write_data;
    logic [7:0]  read_data;

    modport master (
        output reg_address, reg_bytecnt, reg_addrvalid, reg_read, reg_write, write_data,
        input  read_data
    );

    modport slave (
        input  reg_address, reg_bytecnt, reg_addrvalid, reg_read, reg_write, write_data,
        output read_data
    );
endinterface

// File: rtl/reg_capture_fifo.sv
// Capture FIFO: the front end pushes fixed-width entries, and the host pops them byte-wise through
// a data register and reads level, sticky error flags and the high-water mark from a status register.
module reg_capture_fifo #(
    parameter int         pDATA_WIDTH = 18,
    parameter int         pDEPTH_LOG2 = 10,
    parameter logic [5:0] pADDR_DATA  = 6'h20,
    parameter logic [5:0] pADDR_STAT  = 6'h21,
    parameter logic [5:0] pADDR_CTRL  = 6'h22
) (
    input  logic                   cwusb_clk,
    input  logic                   reset_n,
    reg_capture_fifo_if.slave      bus,
    input  logic                   I_wr_en,
    input  logic [pDATA_WIDTH-1:0] I_wr_data,
    output logic                   O_full,
    output logic                   O_empty,
    output logic                   O_overflow,
    output logic [pDEPTH_LOG2:0]   O_level
);
    localparam int NB    = (pDATA_WIDTH + 7) / 8;
    localparam int DEPTH = 1 << pDEPTH_LOG2;

    typedef logic [NB*8-1:0] hold_t;

    logic [pDATA_WIDTH-1:0] mem [DEPTH];
    logic [pDEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [pDEPTH_LOG2:0]   level, hw;
    hold_t                  holding, head_ext;
    logic                   ovf_q, unf_q;
    logic [7:0]             flags, rd_byte;
    logic [15:0]            lvl16, hw16;
    logic                   rd, wr, pop_req, pop, push, flush, clr_flags, clr_hw;
    logic                   ovf_set, unf_set;
    logic                   unused_ok;

    assign rd        = bus.reg_addrvalid & bus.reg_read;
    assign wr        = bus.reg_addrvalid & bus.reg_write;
    assign O_full    = (level == (pDEPTH_LOG2+1)'(DEPTH));
    assign O_empty   = (level == '0);
    assign O_level   = level;
    assign O_overflow = ovf_q;

    assign pop_req   = rd & (bus.reg_address == pADDR_DATA) & (bus.reg_bytecnt == '0);
    assign pop       = pop_req & ~O_empty;
    assign unf_set   = pop_req & O_empty;

    // Control bits act only on byte 0 of the control register.
    assign flush     = wr & (bus.reg_address == pADDR_CTRL) & (bus.reg_bytecnt == '0) & bus.write_data[0];
    assign clr_flags = wr & (bus.reg_address == pADDR_CTRL) & (bus.reg_bytecnt == '0) & bus.write_data[1];
    assign clr_hw    = wr & (bus.reg_address == pADDR_CTRL) & (bus.reg_bytecnt == '0) & bus.write_data[2];

    // Full is judged on the current level; a flush swallows the push without flagging it.
    assign push      = I_wr_en & ~O_full & ~flush;
    assign ovf_set   = I_wr_en & O_full & ~flush;

    assign unused_ok = ^bus.write_data[7:3];

    assign head_ext  = hold_t'(mem[rd_ptr]);
    assign flags     = {4'b0, unf_q, ovf_q, O_full, O_empty};
    assign lvl16     = 16'(level);
    assign hw16      = 16'(hw);

    always_comb begin
        rd_byte = 8'h00;
        if (bus.reg_address == pADDR_DATA) begin
            if (bus.reg_bytecnt == '0)
                rd_byte = pop ? head_ext[7:0] : 8'h00;
            else if (bus.reg_bytecnt == 16'(NB))
                rd_byte = flags;
            else
                for (int i = 1; i < NB; i++)
                    if (bus.reg_bytecnt == 16'(i)) rd_byte = holding[8*i +: 8];
        end else if (bus.reg_address == pADDR_STAT) begin
            case (bus.reg_bytecnt)
                16'd0:   rd_byte = lvl16[7:0];
                16'd1:   rd_byte = lvl16[15:8];
                16'd2:   rd_byte = flags;
                16'd3:   rd_byte = hw16[7:0];
                16'd4:   rd_byte = hw16[15:8];
                default: rd_byte = 8'h00;
            endcase
        end
    end

    // Storage has no reset; contents are meaningless once pointers are cleared.
    always_ff @(posedge cwusb_clk)
        if (push) mem[wr_ptr] <= I_wr_data;

    always_ff @(posedge cwusb_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            hw            <= '0;
            holding       <= '0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
            bus.read_data <= 8'h00;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
            end
            if (pop) holding <= head_ext;
            // A new error in the same cycle as a clear survives the clear.
            ovf_q <= (clr_flags ? 1'b0 : ovf_q) | ovf_set;
            unf_q <= (clr_flags ? 1'b0 : unf_q) | unf_set;
            if (clr_hw)          hw <= level;
            else if (level > hw) hw <= level;
            bus.read_data <= rd ? rd_byte : 8'h00;
        end
    end
endmodule

// File: tb/tb_reg_capture_fifo.sv
// Directed bench for reg_capture_fifo: register reads feed a scoreboard queue checked by a monitor.
module tb_reg_capture_fifo;
    localparam logic [5:0] A_DATA = 6'h20;
    localparam logic [5:0] A_STAT = 6'h21;
    localparam logic [5:0] A_CTRL = 6'h22;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [17:0] wr_data = '0;
    logic        full, empty, overflow;
    logic [10:0] level;
    int          checks = 0;
    int          errors = 0;
    logic        rd_d;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } exp_t;
    exp_t sb[$];

    reg_capture_fifo_if bus ();

    reg_capture_fifo dut (
        .cwusb_clk  (clk),
        .reset_n    (rst_n),
        .bus        (bus.slave),
        .I_wr_en    (wr_en),
        .I_wr_data  (wr_data),
        .O_full     (full),
        .O_empty    (empty),
        .O_overflow (overflow),
        .O_level    (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) rd_d <= 1'b0;
        else        rd_d <= bus.reg_addrvalid & bus.reg_read;

    // Monitor: one expected byte per issued register read.
    always @(negedge clk) begin
        if (rd_d) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read got %02h with empty scoreboard", bus.read_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.read_data !== e.exp) begin
                    errors++;
                    $display("FAIL %s got %02h want %02h", e.name, bus.read_data, e.exp);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.reg_addrvalid = 1'b0;
        bus.reg_read      = 1'b0;
        bus.reg_write     = 1'b0;
    endtask

    task automatic set_rd(input logic [5:0] a, input logic [15:0] bc, input logic [7:0] exp, input string name);
        exp_t e;
        bus.reg_address   = a;
        bus.reg_bytecnt   = bc;
        bus.reg_addrvalid = 1'b1;
        bus.reg_read      = 1'b1;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic rd_reg(input logic [5:0] a, input logic [15:0] bc, input logic [7:0] exp, input string name);
        set_rd(a, bc, exp, name);
        cyc();
        bus_idle();
    endtask

    task automatic set_ctrl(input logic [7:0] v);
        bus.reg_address   = A_CTRL;
        bus.reg_bytecnt   = 16'd0;
        bus.write_data    = v;
        bus.reg_addrvalid = 1'b1;
        bus.reg_write     = 1'b1;
    endtask

    task automatic wr_ctrl(input logic [7:0] v);
        set_ctrl(v);
        cyc();
        bus_idle();
    endtask

    task automatic push(input logic [17:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        cyc();
        wr_en   = 1'b0;
    endtask

    function automatic logic [17:0] v5(input int i);
        return 18'h10000 | 18'(i * 7 + 3);
    endfunction

    initial begin
        bus.reg_address = '0;
        bus.reg_bytecnt = '0;
        bus.write_data  = '0;
        bus_idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset_level", level, 0);
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset_rdata", bus.read_data, 0);

        // Three entries, multi-byte readout
        push(18'h3A5C1); push(18'h00002); push(18'h3FFFF);
        chk("lvl3", level, 3);
        rd_reg(A_DATA, 0, 8'hC1, "data_b0");
        rd_reg(A_DATA, 1, 8'hA5, "data_b1");
        rd_reg(A_DATA, 2, 8'h03, "data_b2");
        rd_reg(A_DATA, 3, 8'h00, "data_flags");
        rd_reg(A_DATA, 4, 8'h00, "data_b4");
        chk("lvl2", level, 2);
        rd_reg(A_STAT, 0, 8'h02, "stat_lvl_lo");
        rd_reg(A_STAT, 1, 8'h00, "stat_lvl_hi");
        rd_reg(A_STAT, 3, 8'h03, "stat_hw_lo");
        rd_reg(A_DATA, 0, 8'h02, "pop_b");
        rd_reg(A_DATA, 0, 8'hFF, "pop_c");
        chk("lvl0", level, 0);

        // Underflow and flag clear, high-water clear
        rd_reg(A_DATA, 0, 8'h00, "unf_read");
        chk("unf_lvl", level, 0);
        rd_reg(A_STAT, 2, 8'h09, "unf_flags");
        wr_ctrl(8'h02);
        rd_reg(A_STAT, 2, 8'h01, "clr_flags");
        wr_ctrl(8'h04);
        rd_reg(A_STAT, 3, 8'h00, "clr_hw");

        // Simultaneous push/pop at level 5
        for (int i = 0; i < 5; i++) push(v5(i));
        for (int k = 0; k < 10; k++) begin
            wr_en   = 1'b1;
            wr_data = v5(5 + k);
            set_rd(A_DATA, 0, v5(k)[7:0], "pushpop");
            cyc();
            wr_en = 1'b0;
            bus_idle();
        end
        chk("pushpop_lvl", level, 5);
        for (int k = 10; k < 15; k++) rd_reg(A_DATA, 0, v5(k)[7:0], "drain5");
        chk("drain_lvl", level, 0);
        rd_reg(A_STAT, 3, 8'h05, "hw5");

        // Fill to full and overflow
        for (int i = 0; i < 1024; i++) push(18'(i));
        chk("full_flag", full, 1);
        chk("full_lvl", level, 1024);
        chk("no_ovf_yet", overflow, 0);
        push(18'h2BEEF);
        chk("ovf_flag", overflow, 1);
        chk("ovf_lvl", level, 1024);
        rd_reg(A_STAT, 0, 8'h00, "full_lvl_lo");
        rd_reg(A_STAT, 1, 8'h04, "full_lvl_hi");
        rd_reg(A_STAT, 2, 8'h06, "full_flags");
        rd_reg(A_STAT, 4, 8'h04, "full_hw_hi");
        wr_en   = 1'b1;
        wr_data = 18'h3FFFF;
        set_rd(A_DATA, 0, 8'h00, "full_pushpop");
        cyc();
        wr_en = 1'b0;
        bus_idle();
        chk("full_pushpop_lvl", level, 1023);
        chk("full_pushpop_full", full, 0);
        rd_reg(A_DATA, 0, 8'h01, "after_full_pop");

        // Flush at level 700 with a same-cycle push
        wr_ctrl(8'h01);
        chk("flush_lvl", level, 0);
        wr_ctrl(8'h06);
        chk("clr_ovf", overflow, 0);
        for (int i = 0; i < 700; i++) push(18'(i + 5));
        chk("lvl700", level, 700);
        wr_en   = 1'b1;
        wr_data = 18'h2DEAD;
        set_ctrl(8'h01);
        cyc();
        wr_en = 1'b0;
        bus_idle();
        chk("flush700_lvl", level, 0);
        chk("flush700_empty", empty, 1);
        chk("flush700_ovf", overflow, 0);
        rd_reg(A_STAT, 3, 8'hBC, "hw700_lo");
        rd_reg(A_STAT, 4, 8'h02, "hw700_hi");
        push(18'h12345);
        rd_reg(A_DATA, 0, 8'h45, "post_flush_pop");

        // Reset while half full and mid multi-byte read
        for (int i = 0; i < 512; i++) push(18'h2AB00 + 18'(i));
        rd_reg(A_DATA, 0, 8'h00, "pre_rst_b0");
        rd_reg(A_DATA, 1, 8'hAB, "pre_rst_b1");
        @(negedge clk);
        #1;
        bus.reg_address   = A_DATA;
        bus.reg_bytecnt   = 16'd2;
        bus.reg_addrvalid = 1'b1;
        bus.reg_read      = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rdata", bus.read_data, 0);
        chk("rst_lvl", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        @(posedge clk);
        #1 bus_idle();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        rd_reg(A_STAT, 2, 8'h01, "post_rst_flags");
        rd_reg(A_STAT, 3, 8'h00, "post_rst_hw");

        cyc(); cyc();
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
